// File: rtl/bcd_pkg.sv
// Shared BCD types, digit bounds and the load sanitiser used by the
// BCD up- and down-counters.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    // Any non-decimal nibble (A-F) is clamped to 9 so a digit can never
    // hold an invalid code.
    function automatic bcd_digit_t bcd_sanitise(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit_dn.sv
// One BCD down-counting digit: loads a sanitised value, decrements on
// dec and wraps 0 -> 9. Saturation at all-zero is decided by the top,
// which withholds dec from every digit when the whole count is zero, so
// an individual digit always wraps when told to decrement.
module bcd_digit_dn
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  bcd_digit_t load_digit,
    input  logic       dec,
    output bcd_digit_t digit,
    output logic       is_zero
);

    bcd_digit_t r_digit;

    // Digit register: load has priority over decrement; reset clears.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_digit <= BCD_MIN;
        end else if (load) begin
            r_digit <= bcd_sanitise(load_digit);
        end else if (dec) begin
            r_digit <= (r_digit == BCD_MIN) ? BCD_MAX : (r_digit - 4'd1);
        end
    end

    assign digit   = r_digit;
    assign is_zero = (r_digit == BCD_MIN);

endmodule

// File: rtl/bcd_down_counter.sv
// Loadable multi-digit BCD down-counter with per-digit borrow enables,
// a combinational zero flag and a registered one-cycle done pulse when a
// decrement takes the count from nonzero to zero.
// Build option: define BCD_DOWN_SAT_EN to saturate at zero instead of
// wrapping 0...0 -> 9...9.
module bcd_down_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  en,
    output logic [4*DIGITS-1:0]   q,
    output logic [DIGITS-1:1]     brw,
    output logic                  zero,
    output logic                  done
);

    logic [DIGITS-1:0] w_is_zero;
    logic [DIGITS-1:0] w_low_zero;   // w_low_zero[i]: all digits below i are 0
    logic              w_count;
    logic              w_upper_zero;
    logic              w_is_one;
    logic              r_done;

`ifdef BCD_DOWN_SAT_EN
    // Saturating build: an all-zero count ignores en entirely.
    assign w_count = en & ~zero;
`else
    assign w_count = en;
`endif

    // Borrow chain: digit i may decrement only when every lower digit is 0.
    always_comb begin
        w_low_zero    = '0;
        w_low_zero[0] = 1'b1;
        for (int i = 1; i < DIGITS; i++) begin
            w_low_zero[i] = w_low_zero[i-1] & w_is_zero[i-1];
        end
    end

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit_dn u_digit (
                .clk        (clk),
                .reset      (reset),
                .load       (load),
                .load_digit (load_val[4*g +: 4]),
                .dec        (w_count & w_low_zero[g]),
                .digit      (q[4*g +: 4]),
                .is_zero    (w_is_zero[g])
            );
        end
    endgenerate

    assign brw  = w_low_zero[DIGITS-1:1];
    assign zero = &w_is_zero;

    // The count is exactly 1 when digit 0 holds 1 and all others are 0;
    // decrementing from there is the only way to reach 0 by counting.
    assign w_upper_zero = &w_is_zero[DIGITS-1:1];
    assign w_is_one     = (q[3:0] == 4'd1) & w_upper_zero;

    // done pulses for one cycle after the decrement that lands on zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= ~load & en & w_is_one;
        end
    end

    assign done = r_done;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Self-checking bench for bcd_down_counter (DIGITS=4): a directed vector
// table, hand-written asynchronous-reset sequences and a randomised run
// against a decimal reference model.
module tb_bcd_down_counter;

    localparam int D = 4;

`ifdef BCD_DOWN_SAT_EN
    localparam logic [15:0] WRAP_Q = 16'h0000;
    localparam bit          SAT    = 1'b1;
`else
    localparam logic [15:0] WRAP_Q = 16'h9999;
    localparam bit          SAT    = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          load;
    logic [15:0]   load_val;
    logic          en;
    logic [15:0]   q;
    logic [3:1]    brw;
    logic          zero;
    logic          done;

    int n_checks = 0;
    int n_pass   = 0;

    bcd_down_counter #(.DIGITS(D)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .q        (q),
        .brw      (brw),
        .zero     (zero),
        .done     (done)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        ld;
        logic [15:0] lv;
        logic        en;
        logic [15:0] exp_q;
        logic        exp_done;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string nm, logic l, logic [15:0] v, logic e,
                                logic [15:0] eq, logic ed);
        vec_t t;
        t.name = nm; t.ld = l; t.lv = v; t.en = e; t.exp_q = eq; t.exp_done = ed;
        vecs.push_back(t);
    endfunction

    function automatic logic [3:1] exp_brw(logic [15:0] v);
        logic [3:1] b;
        b[1] = (v[3:0]  == 4'h0);
        b[2] = (v[7:0]  == 8'h00);
        b[3] = (v[11:0] == 12'h000);
        return b;
    endfunction

    function automatic logic [15:0] to_bcd(int v);
        logic [15:0] r;
        int x;
        x = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int from_sanitised(logic [15:0] v);
        int r;
        int m;
        logic [3:0] d;
        r = 0;
        m = 1;
        for (int i = 0; i < D; i++) begin
            d = v[4*i +: 4];
            if (d > 4'd9) d = 4'd9;
            r = r + int'(d) * m;
            m = m * 10;
        end
        return r;
    endfunction

    task automatic check(string nm, logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic check_all(string nm, logic [15:0] eq, logic ed);
        check({nm, ".q"},    q, eq);
        check({nm, ".done"}, {15'd0, done}, {15'd0, ed});
        check({nm, ".zero"}, {15'd0, zero}, {15'd0, (eq == 16'h0)});
        check({nm, ".brw"},  {13'd0, brw},  {13'd0, exp_brw(eq)});
    endtask

    // Drive on the falling edge, sample 1 unit after the rising edge.
    task automatic step(logic l, logic [15:0] v, logic e);
        @(negedge clk);
        load = l; load_val = v; en = e;
        @(posedge clk);
        #1;
    endtask

    int          m;
    logic        md;
    logic        rl;
    logic [15:0] rv;
    logic        re;

    initial begin
        reset = 1'b0; load = 1'b0; load_val = '0; en = 1'b0;

        // Reset state
        #3;
        check_all("reset", 16'h0000, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        add("load_1002",  1, 16'h1002, 0, 16'h1002, 0);
        add("dec_1001",   0, 16'h0000, 1, 16'h1001, 0);
        add("dec_1000",   0, 16'h0000, 1, 16'h1000, 0);
        add("dec_0999",   0, 16'h0000, 1, 16'h0999, 0);
        add("sanitise",   1, 16'h3AF5, 0, 16'h3995, 0);
        add("load_vs_en", 1, 16'h0050, 1, 16'h0050, 0);
        add("hold",       0, 16'h1234, 0, 16'h0050, 0);
        add("load_0002",  1, 16'h0002, 0, 16'h0002, 0);
        add("dec_0001",   0, 16'h0000, 1, 16'h0001, 0);
        add("dec_to_0",   0, 16'h0000, 1, 16'h0000, 1);
        add("wrap",       0, 16'h0000, 1, WRAP_Q,   0);
        add("load_zero",  1, 16'h0000, 0, 16'h0000, 0);
        add("hold_zero",  0, 16'h0000, 0, 16'h0000, 0);
        add("load_0001",  1, 16'h0001, 1, 16'h0001, 0);
        add("dec_to_0b",  0, 16'h0000, 1, 16'h0000, 1);
        add("done_drop",  0, 16'h0000, 0, 16'h0000, 0);
        add("load_FFFF",  1, 16'hFFFF, 0, 16'h9999, 0);
        add("dec_9998",   0, 16'h0000, 1, 16'h9998, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].ld, vecs[i].lv, vecs[i].en);
            check_all(vecs[i].name, vecs[i].exp_q, vecs[i].exp_done);
        end

        // Asynchronous reset in the middle of a count
        step(1, 16'h0472, 0);
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 1);
        check("midcount.q", q, 16'h0470);
        #2 reset = 1'b0;
        #1 check_all("async_reset", 16'h0000, 1'b0);
        @(posedge clk); #1;
        check_all("reset_held", 16'h0000, 1'b0);
        @(negedge clk);
        reset = 1'b1; en = 1'b0;

        // Reset while done is high clears it at once
        step(1, 16'h0001, 0);
        step(0, 16'h0000, 1);
        check_all("pre_reset_done", 16'h0000, 1'b1);
        #1 reset = 1'b0;
        #1 check_all("reset_clears_done", 16'h0000, 1'b0);
        @(negedge clk);
        reset = 1'b1; en = 1'b0;
        step(0, 16'h0000, 0);
        check_all("after_reset", 16'h0000, 1'b0);

        // Random run against a decimal model
        m = 0;
        for (int c = 0; c < 10000; c++) begin
            rl = ($urandom_range(0, 15) == 0);
            rv = ($urandom_range(0, 3) == 0) ? 16'($urandom) : to_bcd($urandom_range(0, 12));
            re = 1'($urandom_range(0, 1));
            if (rl) begin
                m  = from_sanitised(rv);
                md = 1'b0;
            end else if (re) begin
                if (m == 0) begin
                    m  = SAT ? 0 : 9999;
                    md = 1'b0;
                end else begin
                    m  = m - 1;
                    md = (m == 0);
                end
            end else begin
                md = 1'b0;
            end
            step(rl, rv, re);
            check_all("random", to_bcd(m), md);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
